// File: rtl/button_events_pkg.sv
// Shared definitions for the push-button conditioning chain: FSM encoding,
// default board timing constants and counter sizing.
package button_events_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HELD      = 2'd1,
        LONG_HELD = 2'd2
    } btn_state_e;

    localparam int CLK_HZ        = 25000000;
    localparam int DEBOUNCE_10MS = 250000;
    localparam int LONG_1S       = 25000000;

    // Counter width for a terminal count of n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_events_debounce_filter.sv
// Two-flop synchronizer followed by a disagreement-run debounce counter.
// o_Rise/o_Fall announce the o_Level flip that happens on the next edge.
module debounce_filter
    import button_events_pkg::*;
#(
    parameter int DEBOUNCE_TIME = DEBOUNCE_10MS
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Level,
    output logic o_Rise,
    output logic o_Fall
);

    localparam int CW = cnt_width(DEBOUNCE_TIME);
    localparam logic [CW-1:0] DEB_TERM = CW'(DEBOUNCE_TIME - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_count;
    logic          r_level;

    logic          w_differ;
    logic          w_flip;
    logic [CW-1:0] w_count_next;
    logic          w_level_next;

    assign w_differ = r_sync2 ^ r_level;
    assign w_flip   = w_differ && (r_count >= DEB_TERM);

    // Debounce counter: any cycle of agreement restarts the run.
    always_comb begin
        w_count_next = r_count;
        w_level_next = r_level;
        if (!w_differ) begin
            w_count_next = '0;
        end else if (w_flip) begin
            w_count_next = '0;
            w_level_next = ~r_level;
        end else begin
            w_count_next = r_count + CW'(1);
        end
    end

    // Synchronizer, counter and debounced level registers.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_count <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync1 <= i_Switch;
            r_sync2 <= r_sync1;
            r_count <= w_count_next;
            r_level <= w_level_next;
        end
    end

    assign o_Level = r_level;
    assign o_Rise  = w_flip & ~r_level;
    assign o_Fall  = w_flip & r_level;

endmodule

// File: rtl/button_events.sv
// Push-button event generator: debounced level plus single-cycle press,
// release, short-press and long-press pulses for the stopwatch.
module button_events
    import button_events_pkg::*;
#(
    parameter int DEBOUNCE_TIME   = DEBOUNCE_10MS,
    parameter int LONG_PRESS_TIME = LONG_1S
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Level,
    output logic o_Press,
    output logic o_Release,
    output logic o_Short,
    output logic o_Long
);

    localparam int HW = cnt_width(LONG_PRESS_TIME);
    localparam logic [HW-1:0] HOLD_TERM = HW'(LONG_PRESS_TIME - 1);

    btn_state_e    r_state;
    btn_state_e    w_state_next;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_next;
    logic          r_press;
    logic          r_release;
    logic          r_short;
    logic          r_long;
    logic          w_press_next;
    logic          w_release_next;
    logic          w_short_next;
    logic          w_long_next;
    logic          w_rise;
    logic          w_fall;

    debounce_filter #(
        .DEBOUNCE_TIME (DEBOUNCE_TIME)
    ) u_debounce (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_Switch (i_Switch),
        .o_Level  (o_Level),
        .o_Rise   (w_rise),
        .o_Fall   (w_fall)
    );

    // Pulses are decided from the filter's flip strobes so they land in the
    // same cycle the new level appears; a release beats a simultaneous long.
    always_comb begin
        w_state_next   = r_state;
        w_hold_next    = r_hold;
        w_press_next   = 1'b0;
        w_release_next = 1'b0;
        w_short_next   = 1'b0;
        w_long_next    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_press_next = 1'b1;
                    w_hold_next  = '0;
                    w_state_next = HELD;
                end else begin
                    w_state_next = IDLE;
                end
            end
            HELD: begin
                if (w_fall) begin
                    w_release_next = 1'b1;
                    w_short_next   = 1'b1;
                    w_state_next   = IDLE;
                end else if (r_hold >= HOLD_TERM) begin
                    w_long_next  = 1'b1;
                    w_state_next = LONG_HELD;
                end else begin
                    w_hold_next = r_hold + HW'(1);
                end
            end
            LONG_HELD: begin
                if (w_fall) begin
                    w_release_next = 1'b1;
                    w_state_next   = IDLE;
                end else begin
                    w_state_next = LONG_HELD;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_hold_next  = '0;
            end
        endcase
    end

    // State, hold counter and registered event pulses.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state   <= IDLE;
            r_hold    <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_hold    <= w_hold_next;
            r_press   <= w_press_next;
            r_release <= w_release_next;
            r_short   <= w_short_next;
            r_long    <= w_long_next;
        end
    end

    assign o_Press   = r_press;
    assign o_Release = r_release;
    assign o_Short   = r_short;
    assign o_Long    = r_long;

endmodule

// File: doc/button_events.md
Name: button_events

Overview:
- Upstream input stage for the stopwatch. It conditions one raw push-button into clean, single-cycle event pulses.
- The chain is: 2-FF synchronizer, then debounce filter, then press/hold state machine.
- The stopwatch consumes o_Short to toggle start/stop and o_Long to reset.
- The board instantiates one copy per physical switch.

Parameters:
- DEBOUNCE_TIME, 250000, consecutive cycles the synchronized input must differ from the debounced level before that level flips (10 ms at 25 MHz).
- LONG_PRESS_TIME, 25000000, cycles the debounced level must stay high, counted from o_Press, before o_Long fires (1 s at 25 MHz).

Ports:
- i_Clk  in  1  system clock, 25 MHz.
- i_Rst_L  in  1  asynchronous reset, active-low.
- i_Switch  in  1  raw, asynchronous, bouncing button level (1 = pressed).
- o_Level  out  1  debounced button level.
- o_Press  out  1  one-cycle pulse on a debounced press.
- o_Release  out  1  one-cycle pulse on every debounced release.
- o_Short  out  1  one-cycle pulse on a release whose press did not reach LONG_PRESS_TIME.
- o_Long  out  1  one-cycle pulse when the hold reaches LONG_PRESS_TIME; fires at most once per press.

Behaviour:
- Reset (i_Rst_L = 0, asynchronous):
  - Synchronizer FFs, debounce counter, hold counter, o_Level and all pulses go to 0.
  - FSM goes to IDLE.
  - Reset mid-press discards all progress.
  - After reset deasserts, a button already held must be debounced again from zero. It then produces o_Press normally.
- Synchronizer: two flops. The filter sees s_Switch = i_Switch delayed by 2 edges.
- Debounce filter:
  - When s_Switch equals o_Level, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_TIME-1 while s_Switch still differs, o_Level toggles at the next edge and the counter clears.
  - Any single cycle of agreement restarts the count. A glitch shorter than DEBOUNCE_TIME cycles never changes o_Level.
  - Latency from a clean raw change to the o_Level change is DEBOUNCE_TIME+2 edges.
  - Counter width is $clog2(DEBOUNCE_TIME). It never wraps.
- FSM states:
  - IDLE, waiting for a press. On o_Level 0→1: pulse o_Press, clear the hold counter, go to HELD.
  - HELD, pressed and not yet long.
    - The hold counter increments each cycle.
    - When the counter reaches LONG_PRESS_TIME-1: pulse o_Long, go to LONG_HELD.
    - On o_Level 1→0: pulse o_Release and o_Short in the same cycle, go to IDLE.
  - LONG_HELD, pressed after o_Long has fired.
    - The hold counter stops and saturates.
    - On o_Level 1→0: pulse o_Release only (no o_Short), go to IDLE.
- Pulse timing:
  - All pulses are registered and high for exactly one cycle.
  - Each pulse is asserted in the same cycle that o_Level first shows its new value.
  - o_Long is asserted exactly LONG_PRESS_TIME cycles after the o_Press cycle.
- Boundary conditions:
  - Release debounced in the same cycle the hold counter hits its terminal value: release wins, giving o_Short and no o_Long.
  - o_Press, o_Long and o_Release are mutually exclusive in any cycle. o_Short only ever coincides with o_Release.
  - The minimum time between o_Press and o_Release is DEBOUNCE_TIME cycles. The filter guarantees this; no extra lockout is needed.
- Width rules: hold counter width is $clog2(LONG_PRESS_TIME). Compare with >= so a parameter change cannot cause a wrap.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, HELD=2'd1, LONG_HELD=2'd2.
  - The default timing constants CLK_HZ=25000000, DEBOUNCE_10MS=250000 and LONG_1S=25000000, also shared by the stopwatch.
- One natural sub-module, debounce_filter (synchronizer plus counter, output o_Level), instantiated once. The FSM lives in button_events.

Test Plan (bench uses DEBOUNCE_TIME=50, LONG_PRESS_TIME=400, 40 ns clock):
- Reset check: hold i_Rst_L=0 for 5 cycles with i_Switch=1, then release reset -> all outputs 0 during reset; o_Press fires exactly 52 edges after reset deasserts.
- Glitch rejection: pulse i_Switch high for 49 cycles, then low -> o_Level stays 0; no pulse of any kind.
- Short press: 4 bounces of 3 cycles, hold high 150 cycles, release with 4 bounces -> exactly one o_Press and one o_Release+o_Short; o_Long never fires; o_Level high for 150±12 cycles.
- Long press: clean press held 1000 cycles -> o_Long exactly 400 cycles after o_Press, once only; release gives o_Release without o_Short.
- Boundary: release timed so the debounced fall lands on hold count 399 -> o_Release+o_Short, no o_Long.
- Reset mid-hold: assert i_Rst_L=0 200 cycles after o_Press for 3 cycles while still pressed -> outputs clear asynchronously; after reset a fresh o_Press arrives 52 edges later; o_Long fires 400 cycles after that new o_Press.
